mem_req_arbiter: RTL

Two-port arbiter that shares one `memory_system`-style data-memory port between requester 0 (load/store queue) and requester 1 (secondary requester, e.g. fetch-miss or debug port). It applies round-robin arbitration and remaps each requester's 4-bit ld/st id onto a free memory tag. It buffers the winning request in a one-entry output register that obeys the memory stall. It routes out-of-order memory responses back to the originating requester with its original id. It sits between the LSQ and the data cache.

---
 rtl/mem_req_arbiter_pkg.sv | 14 +
 rtl/mem_req_arbiter_tag_alloc.sv | 45 ++++
 rtl/mem_req_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: memory tag sizing and the request record shared by the LSQ, the arbiter and the data cache
package mem_req_arbiter_pkg;
  localparam int MEM_TAG_W = 4;
  localparam int MEM_TAGS = 16;
  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;
  typedef logic [MEM_TAG_W-1:0] tag_t;
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    tag_t        id;
  } mem_req_t;
endpackage

// File: rtl/mem_req_arbiter_tag_alloc.sv
// mem_req_arbiter_tag_alloc: busy vector, lowest-free tag encode and outstanding count
module mem_req_arbiter_tag_alloc
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_i,
  input  logic                rel_i,
  input  tag_t                rel_tag_i,
  output tag_t                free_tag_o,
  output logic                tag_ok_o,
  output logic [4:0]          count_o,
  output logic [MEM_TAGS-1:0] busy_o
);
  localparam logic [MEM_TAGS-1:0] MASK = MEM_TAGS'((17'd1 << MAX_OUT) - 17'd1);
  logic [MEM_TAGS-1:0] busy_q, busy_d;
  logic [4:0] cnt_q;
  assign tag_ok_o = |(MASK & ~busy_q);
  assign count_o = cnt_q;
  assign busy_o = busy_q;
  // lowest-numbered free tag among the allowed range, taken from the registered busy state
  always_comb begin
    free_tag_o = '0;
    for (int i = MEM_TAGS - 1; i >= 0; i--)
      if (MASK[i] && !busy_q[i]) free_tag_o = tag_t'(i);
  end
  // the released tag is always busy and the allocated one always free, so they never collide
  always_comb begin
    busy_d = busy_q;
    if (rel_i) busy_d[rel_tag_i] = 1'b0;
    if (alloc_i) busy_d[free_tag_o] = 1'b1;
  end
  // busy vector and count advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_q + 5'(alloc_i) - 5'(rel_i);
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of one tagged memory port between two requesters with id remapping
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid_in,
  input  logic        r0_rw_in,
  input  logic [31:0] r0_addr_in,
  input  logic [31:0] r0_data_in,
  input  logic [3:0]  r0_id_in,
  output logic        r0_stall_out,
  output logic        r0_ready_out,
  output logic [31:0] r0_data_out,
  output logic [3:0]  r0_id_out,
  input  logic        r1_valid_in,
  input  logic        r1_rw_in,
  input  logic [31:0] r1_addr_in,
  input  logic [31:0] r1_data_in,
  input  logic [3:0]  r1_id_in,
  output logic        r1_stall_out,
  output logic        r1_ready_out,
  output logic [31:0] r1_data_out,
  output logic [3:0]  r1_id_out,
  output logic        mem_valid_out,
  output logic        mem_rw_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_id_out,
  input  logic        mem_stall_in,
  input  logic        mem_ready_in,
  input  logic [3:0]  mem_id_in,
  input  logic [31:0] mem_data_in,
  output logic [4:0]  outstanding_out,
  output logic        err_out
);
  localparam logic [4:0] MAX_L = 5'(MAX_OUT);
  logic out_valid_q, prio_q, err_q;
  mem_req_t out_q;
  logic [MEM_TAGS-1:0] owner_q;
  tag_t oid_q [MEM_TAGS];
  logic r0_ready_q, r1_ready_q;
  logic [31:0] r0_data_q, r1_data_q;
  tag_t r0_id_q, r1_id_q;
  logic slot_ok, tag_ok, grant0, grant1, grant, rel, rel_own;
  tag_t free_tag;
  logic [MEM_TAGS-1:0] busy;
  assign slot_ok = !out_valid_q || !mem_stall_in;
  assign grant0 = slot_ok && tag_ok && r0_valid_in && (!r1_valid_in || !prio_q);
  assign grant1 = slot_ok && tag_ok && r1_valid_in && (!r0_valid_in || prio_q);
  assign grant = grant0 || grant1;
  assign rel = mem_ready_in && ({1'b0, mem_id_in} < MAX_L) && busy[mem_id_in];
  assign rel_own = owner_q[mem_id_in];
  assign r0_stall_out = r0_valid_in && !grant0;
  assign r1_stall_out = r1_valid_in && !grant1;
  assign r0_ready_out = r0_ready_q;
  assign r0_data_out = r0_data_q;
  assign r0_id_out = r0_id_q;
  assign r1_ready_out = r1_ready_q;
  assign r1_data_out = r1_data_q;
  assign r1_id_out = r1_id_q;
  assign mem_valid_out = out_valid_q;
  assign mem_rw_out = out_q.rw;
  assign mem_addr_out = out_q.addr;
  assign mem_data_out = out_q.data;
  assign mem_id_out = out_q.id;
  assign err_out = err_q;
  mem_req_arbiter_tag_alloc #(.MAX_OUT(MAX_OUT)) u_tag_alloc (
    .clk       (clk),
    .rst       (rst),
    .alloc_i   (grant),
    .rel_i     (rel),
    .rel_tag_i (mem_id_in),
    .free_tag_o(free_tag),
    .tag_ok_o  (tag_ok),
    .count_o   (outstanding_out),
    .busy_o    (busy)
  );
  // owner and original id of each tag; only meaningful while the tag is busy
  always_ff @(posedge clk) begin
    if (grant) begin
      owner_q[free_tag] <= grant1;
      oid_q[free_tag] <= grant0 ? r0_id_in : r1_id_in;
    end
  end
  // output register, round-robin pointer, response routing and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q <= '{rw: REQ_RD, default: '0};
      prio_q <= 1'b0;
      err_q <= 1'b0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_data_q <= '0;
      r1_data_q <= '0;
      r0_id_q <= '0;
      r1_id_q <= '0;
    end else begin
      if (grant) begin
        out_valid_q <= 1'b1;
        out_q <= grant0 ? {r0_rw_in, r0_addr_in, r0_data_in, free_tag} : {r1_rw_in, r1_addr_in, r1_data_in, free_tag};
        prio_q <= grant0;
      end else if (!mem_stall_in) out_valid_q <= 1'b0;
      r0_ready_q <= rel && !rel_own;
      r1_ready_q <= rel && rel_own;
      if (rel && !rel_own) begin
        r0_data_q <= mem_data_in;
        r0_id_q <= oid_q[mem_id_in];
      end
      if (rel && rel_own) begin
        r1_data_q <= mem_data_in;
        r1_id_q <= oid_q[mem_id_in];
      end
      if (mem_ready_in && !rel) err_q <= 1'b1;
    end
  end
endmodule
